// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter for a single-ported synchronous RAM.
//               An instruction-fetch port and a data port share one RAM
//               port. Data normally has priority. A starvation counter forces
//               a fetch grant after STARVE_MAX consecutive fetch losses.
//               The read latency is one cycle. The owner of each pending read
//               is tracked, so the returned word is steered to the correct
//               requester. A new grant can be issued in the same cycle as a
//               previous read's rvalid, giving full throughput.
// Ports       : clk, rst (sync, active low)
//               fetch : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//               data  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid,
//                       d_rdata
//               RAM   : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//               hazard: stall_if
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if
);

    // Pending-read owner encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD_I = 2'd1;
    localparam logic [1:0] c_RD_D = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0] r_state;
    logic [3:0] r_starve_cnt;

    logic w_i_win;
    logic w_i_gnt;
    logic w_d_gnt;

    // Fetch wins when it is alone, or when it has lost STARVE_MAX times in a row.
    assign w_i_win = i_req & (~d_req | (r_starve_cnt == c_STARVE_MAX));

    // rst is active low. All grants are suppressed while reset is held.
    assign w_i_gnt = rst & w_i_win;
    assign w_d_gnt = rst & d_req & ~w_i_win;

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign mem_en   = w_i_gnt | w_d_gnt;
    assign stall_if = rst & i_req & ~w_i_gnt;

    // Only the granted side reaches the RAM. The other side's inputs are don't-care.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 4'd0;
        mem_wdata = 32'd0;
        if (w_i_gnt) begin
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end
    end

    assign i_rvalid = (r_state == c_RD_I);
    assign d_rvalid = (r_state == c_RD_D);
    assign i_rdata  = i_rvalid ? mem_rdata : 32'd0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_starve_cnt <= 4'd0;
        end else begin
            // Next state depends only on this cycle's grant, which lets reads
            // issue back to back.
            if (w_i_gnt) begin
                r_state <= c_RD_I;
            end else if (w_d_gnt && (d_we == 4'd0)) begin
                r_state <= c_RD_D;
            end else begin
                r_state <= c_IDLE;
            end

            if (i_req && !w_i_gnt) begin
                if (r_starve_cnt != c_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire
